ip_rx_sequencer: RTL and testbench
==================================

// Module: ip_rx_sequencer
// PURPOSE
// - Sequences the IPv4 receive path: accepts a byte stream starting at the IPv4 header, feeds the
//   header into the ip_decode datapath, waits for its done/err verdict and filters on destination.
// - Forwards exactly (total_length - HDR_BYTES) payload bytes downstream, or drops the packet.
// - Sits between the Ethernet RX demux (ethertype 0x0800) and the TCP receive logic.
// PARAMETERS
// HDR_BYTES     20  header bytes fed to decoder (IHL=5 only; options unsupported)
// TIMEOUT       8   max cycles in WAIT for dec_done/dec_err before forced drop
// CNT_W         16  width of drop_count (saturating)
// ACCEPT_BCAST  1   1 = also accept da 32'hFFFFFFFF
// PORTS
// clk        in   1      clock
// rst        in   1      reset, synchronous, active-high
// s_valid    in   1      input byte valid
// s_data     in   8      input byte
// s_last     in   1      last byte of frame
// s_ready    out  1      input accept (comb.); transfer = s_valid & s_ready
// local_ip   in   32     this node's IPv4 address
// dec_valid  out  1      to ip_decode.valid (registered)
// dec_din    out  8      to ip_decode.din (registered)
// dec_done   in   1      from ip_decode.done
// dec_err    in   1      from ip_decode.err
// dec_da     in   32     from ip_decode.da
// m_valid    out  1      payload byte valid
// m_data     out  8      payload byte
// m_last     out  1      last payload byte
// m_ready    in   1      downstream accept
// pkt_ok     out  1      1-cycle pulse: payload fully delivered
// pkt_drop   out  1      1-cycle pulse: packet discarded
// drop_count out  CNT_W  saturating count of pkt_drop pulses
// BEHAVIOUR
// - Reset: state IDLE; dec_valid, dec_din, pkt_ok, pkt_drop, drop_count = 0; s_ready = m_valid = 0 during rst.
// - States: IDLE, HDR, WAIT, PAYLOAD, TRAIL, DROP.
// - IDLE/HDR: s_ready=1. Each transfer: dec_din<=s_data, dec_valid<=1, hdr_cnt++. Header bytes 2,3
//   captured as total_len (big-endian). First transfer in IDLE -> HDR (hdr_cnt=1).
// - HDR: after the HDR_BYTES-th transfer -> WAIT. s_last on any header byte -> pkt_drop, IDLE.
// - WAIT: s_ready=0; dec_valid held 1, dec_din held. Timer counts cycles in WAIT.
//   - dec_err=1 (priority over done) -> DROP.
//   - dec_done=1 & da match (dec_da==local_ip, or bcast if ACCEPT_BCAST) & total_len>=HDR_BYTES:
//     rem<=total_len-HDR_BYTES; rem==0 -> pkt_ok, then TRAIL (or IDLE if header byte HDR_BYTES had s_last);
//     else PAYLOAD.
//   - done with no match / total_len<HDR_BYTES, or timer reaches TIMEOUT -> DROP.
// - dec_valid <= 0 on any exit from HDR or WAIT (resets decoder for next packet).
// - PAYLOAD: comb. pass-through: m_valid=s_valid, m_data=s_data, s_ready=m_ready, m_last=(rem==1)|s_last.
//   Each transfer rem--. Transfer with rem==1: pkt_ok; s_last ? IDLE : TRAIL.
//   Transfer with s_last and rem>1 (truncated): m_last=1, pkt_drop, IDLE.
// - TRAIL: s_ready=1, discard Ethernet padding until s_last transfer -> IDLE; no pulse, no count.
// - DROP: s_ready=1, discard until s_last transfer -> pkt_drop, IDLE. A source that already sent
//   s_last in the header still produces exactly one pkt_drop.
// - drop_count += 1 per pkt_drop pulse, saturates at all-ones.
// - m_valid=0 outside PAYLOAD. Payload data latency 0 (comb.); decoder latency absorbed by WAIT stall.
// - Reset mid-packet: immediate IDLE, no pulses; stream resyncs at next byte (upstream resets too).
// TESTING
// - total_len=24, da=local_ip, dec_done after header, payload 11 22 33 44+s_last -> 4 m beats, m_last on 44, pkt_ok=1.
// - da=10.0.0.9 != local_ip=10.0.0.1 -> m_valid never 1, bytes drained to s_last, pkt_drop, drop_count=1.
// - dec_err=1 with dec_done=1 same cycle -> DROP, pkt_drop; no decoder response for 8 cycles -> DROP, pkt_drop.
// - total_len=22, frame padded to 46 bytes -> 2 payload beats, m_last on 2nd, pkt_ok, padding consumed, no drop.
// - m_ready toggling 1010 in PAYLOAD -> s_ready mirrors m_ready, no byte lost/duplicated.
// - s_last at header byte 10 -> pkt_drop, dec_valid falls next cycle; rst mid-PAYLOAD -> IDLE, counters 0.

Source files
------------

// File: rtl/ip_rx_sequencer.sv
// IPv4 receive sequencer: feeds the header into ip_decode, waits for its verdict,
// filters on destination address and forwards exactly (total_length - HDR_BYTES)
// payload bytes downstream, otherwise drains and drops the packet.
module ip_rx_sequencer #(
    parameter int unsigned HDR_BYTES    = 20,
    parameter int unsigned TIMEOUT      = 8,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned ACCEPT_BCAST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic             s_ready,
    input  logic [31:0]      local_ip,
    output logic             dec_valid,
    output logic [7:0]       dec_din,
    input  logic             dec_done,
    input  logic             dec_err,
    input  logic [31:0]      dec_da,
    output logic             m_valid,
    output logic [7:0]       m_data,
    output logic             m_last,
    input  logic             m_ready,
    output logic             pkt_ok,
    output logic             pkt_drop,
    output logic [CNT_W-1:0] drop_count
);

    localparam int unsigned HdrCntW = $clog2(HDR_BYTES + 1);
    localparam int unsigned TimerW  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StWait,
        StPayload,
        StTrail,
        StDrop
    } state_e;

    state_e             state_q, state_d;
    logic [HdrCntW-1:0] hdr_cnt_q, hdr_cnt_d;
    logic [15:0]        total_len_q, total_len_d;
    logic [15:0]        rem_q, rem_d;
    logic [TimerW-1:0]  timer_q, timer_d;
    logic               hdr_last_q, hdr_last_d;
    logic               dec_valid_q, dec_valid_d;
    logic [7:0]         dec_din_q, dec_din_d;
    logic               pkt_ok_q, pkt_ok_d;
    logic               pkt_drop_q, pkt_drop_d;
    logic [CNT_W-1:0]   drop_count_q, drop_count_d;

    logic s_xfer;
    logic da_match;
    logic len_ok;
    logic timed_out;

    assign s_xfer    = s_valid & s_ready;
    assign da_match  = (dec_da == local_ip) ||
                       ((ACCEPT_BCAST != 0) && (dec_da == 32'hFFFF_FFFF));
    assign len_ok    = (total_len_q >= 16'(HDR_BYTES));
    // Last permitted WAIT cycle; without a verdict here the packet is dropped.
    assign timed_out = (timer_q == TimerW'(TIMEOUT - 1));

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            hdr_cnt_q    <= '0;
            total_len_q  <= '0;
            rem_q        <= '0;
            timer_q      <= '0;
            hdr_last_q   <= 1'b0;
            dec_valid_q  <= 1'b0;
            dec_din_q    <= '0;
            pkt_ok_q     <= 1'b0;
            pkt_drop_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            hdr_cnt_q    <= hdr_cnt_d;
            total_len_q  <= total_len_d;
            rem_q        <= rem_d;
            timer_q      <= timer_d;
            hdr_last_q   <= hdr_last_d;
            dec_valid_q  <= dec_valid_d;
            dec_din_q    <= dec_din_d;
            pkt_ok_q     <= pkt_ok_d;
            pkt_drop_q   <= pkt_drop_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        total_len_d = total_len_q;
        rem_d       = rem_q;
        timer_d     = '0;
        hdr_last_d  = hdr_last_q;
        dec_valid_d = dec_valid_q;
        dec_din_d   = dec_din_q;
        pkt_ok_d    = 1'b0;
        pkt_drop_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (s_xfer) begin
                    dec_valid_d = 1'b1;
                    dec_din_d   = s_data;
                    hdr_cnt_d   = HdrCntW'(1);
                    hdr_last_d  = 1'b0;
                    if (s_last) begin
                        // One-byte frame: cannot be a header, discard it.
                        dec_valid_d = 1'b0;
                        pkt_drop_d  = 1'b1;
                    end else begin
                        state_d = StHdr;
                    end
                end
            end

            StHdr: begin
                if (s_xfer) begin
                    dec_valid_d = 1'b1;
                    dec_din_d   = s_data;
                    hdr_cnt_d   = hdr_cnt_q + HdrCntW'(1);
                    if (hdr_cnt_q == HdrCntW'(2)) begin
                        total_len_d[15:8] = s_data;
                    end
                    if (hdr_cnt_q == HdrCntW'(3)) begin
                        total_len_d[7:0] = s_data;
                    end
                    if (hdr_cnt_q == HdrCntW'(HDR_BYTES - 1)) begin
                        // Final header byte: remember s_last so WAIT knows no bytes follow.
                        state_d    = StWait;
                        hdr_last_d = s_last;
                    end else if (s_last) begin
                        dec_valid_d = 1'b0;
                        pkt_drop_d  = 1'b1;
                        state_d     = StIdle;
                    end
                end
            end

            StWait: begin
                timer_d = timer_q + TimerW'(1);
                if (dec_err || (dec_done && !(da_match && len_ok)) ||
                    (!dec_done && timed_out)) begin
                    dec_valid_d = 1'b0;
                    if (hdr_last_q) begin
                        // Frame already ended; nothing left to drain.
                        pkt_drop_d = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        state_d = StDrop;
                    end
                end else if (dec_done) begin
                    dec_valid_d = 1'b0;
                    rem_d       = total_len_q - 16'(HDR_BYTES);
                    if (total_len_q == 16'(HDR_BYTES)) begin
                        pkt_ok_d = 1'b1;
                        state_d  = hdr_last_q ? StIdle : StTrail;
                    end else if (hdr_last_q) begin
                        // Payload expected but frame already ended: truncated.
                        pkt_drop_d = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        state_d = StPayload;
                    end
                end
            end

            StPayload: begin
                if (s_xfer) begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        pkt_ok_d = 1'b1;
                        state_d  = s_last ? StIdle : StTrail;
                    end else if (s_last) begin
                        pkt_drop_d = 1'b1;
                        state_d    = StIdle;
                    end
                end
            end

            StTrail: begin
                if (s_xfer && s_last) begin
                    state_d = StIdle;
                end
            end

            StDrop: begin
                if (s_xfer && s_last) begin
                    pkt_drop_d = 1'b1;
                    state_d    = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        drop_count_d = drop_count_q;
        if (pkt_drop_d && (drop_count_q != '1)) begin
            drop_count_d = drop_count_q + CNT_W'(1);
        end
    end

    // Stream handshake outputs; payload is a combinational pass-through.
    always_comb begin
        s_ready = 1'b0;
        m_valid = 1'b0;
        m_data  = s_data;
        m_last  = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StIdle, StHdr, StTrail, StDrop: begin
                    s_ready = 1'b1;
                end
                StWait: begin
                    s_ready = 1'b0;
                end
                StPayload: begin
                    s_ready = m_ready;
                    m_valid = s_valid;
                    m_last  = (rem_q == 16'd1) | s_last;
                end
                default: begin
                    s_ready = 1'b0;
                end
            endcase
        end
    end

    assign dec_valid  = dec_valid_q;
    assign dec_din    = dec_din_q;
    assign pkt_ok     = pkt_ok_q;
    assign pkt_drop   = pkt_drop_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_ip_rx_sequencer.sv
// Directed bench for ip_rx_sequencer: a table of packet records plus hand-written
// sequences for header truncation and reset in the middle of a payload.
module tb_ip_rx_sequencer;

    localparam logic [31:0] LocalIp = 32'h0A00_0001;
    localparam logic [31:0] OtherIp = 32'h0A00_0009;
    localparam logic [31:0] BcastIp = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [31:0] local_ip = LocalIp;
    logic        dec_valid;
    logic [7:0]  dec_din;
    logic        dec_done = 1'b0;
    logic        dec_err = 1'b0;
    logic [31:0] dec_da = 32'h0;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_last;
    logic        m_ready = 1'b1;
    logic        pkt_ok;
    logic        pkt_drop;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    ip_rx_sequencer #(
        .HDR_BYTES   (20),
        .TIMEOUT     (8),
        .CNT_W       (16),
        .ACCEPT_BCAST(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .local_ip  (local_ip),
        .dec_valid (dec_valid),
        .dec_din   (dec_din),
        .dec_done  (dec_done),
        .dec_err   (dec_err),
        .dec_da    (dec_da),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .pkt_ok    (pkt_ok),
        .pkt_drop  (pkt_drop),
        .drop_count(drop_count)
    );

    // mode: 0 = done, 1 = err together with done, 2 = no decoder response
    typedef struct {
        logic [15:0] tl;
        logic [31:0] da;
        int          mode;
        int          nafter;
        bit          tog;
        int          exp_beats;
        int          exp_ok;
        int          exp_drop;
        int          exp_dcount;
    } vec_t;

    vec_t       vecs[8];
    int         errors = 0;
    int         checks = 0;
    int         ok_seen = 0;
    int         drop_seen = 0;
    logic [8:0] beat_q[$];
    bit         tog_ph = 1'b1;

    // Observe payload beats and pulses half a cycle away from the active edge.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (m_valid && m_ready) beat_q.push_back({m_last, m_data});
            if (pkt_ok) ok_seen++;
            if (pkt_drop) drop_seen++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pay_byte(input int k);
        return 8'((k + 1) * 17);
    endfunction

    function automatic logic [7:0] hdr_byte(input int i, input logic [15:0] tl);
        logic [7:0] b;
        case (i)
            0:       b = 8'h45;
            2:       b = tl[15:8];
            3:       b = tl[7:0];
            default: b = 8'(i);
        endcase
        return b;
    endfunction

    task automatic drive_ready(input bit tog);
        if (tog) begin
            m_ready = tog_ph;
            tog_ph  = ~tog_ph;
        end else begin
            m_ready = 1'b1;
        end
    endtask

    // Offer one byte and hold it until accepted (bounded).
    task automatic push(input logic [7:0] d, input logic l, input bit tog);
        int guard = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        drive_ready(tog);
        #1;
        if (tog) check("s_ready_mirrors_m_ready", 32'(s_ready), 32'(m_ready));
        while (!s_ready && guard < 60) begin
            @(negedge clk);
            drive_ready(tog);
            #1;
            guard++;
            if (tog) check("s_ready_mirrors_m_ready", 32'(s_ready), 32'(m_ready));
        end
        if (guard >= 60) begin
            checks++;
            errors++;
            $display("FAIL xfer_bound: byte %0h not accepted within 60 cycles", d);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
    endtask

    task automatic send_hdr(input logic [15:0] tl, input logic last_on_end);
        for (int i = 0; i < 20; i++) push(hdr_byte(i, tl), (i == 19) && last_on_end, 1'b0);
    endtask

    task automatic respond(input logic [31:0] da, input int mode);
        if (mode != 2) begin
            @(negedge clk);
            dec_da   = da;
            dec_done = 1'b1;
            dec_err  = (mode == 1);
            @(posedge clk);
            #1;
            dec_done = 1'b0;
            dec_err  = 1'b0;
        end
    endtask

    task automatic run_pkt(input vec_t v, input int idx);
        beat_q.delete();
        ok_seen   = 0;
        drop_seen = 0;
        tog_ph    = 1'b1;
        send_hdr(v.tl, v.nafter == 0);
        respond(v.da, v.mode);
        for (int k = 0; k < v.nafter; k++)
            push(pay_byte(k), k == v.nafter - 1, v.tog && (k < v.exp_beats));
        repeat (3) @(negedge clk);
        #2;
        check($sformatf("v%0d_beats", idx), 32'(beat_q.size()), 32'(v.exp_beats));
        for (int j = 0; j < beat_q.size() && j < v.exp_beats; j++) begin
            check($sformatf("v%0d_beat%0d_data", idx, j), 32'(beat_q[j][7:0]), 32'(pay_byte(j)));
            check($sformatf("v%0d_beat%0d_last", idx, j), 32'(beat_q[j][8]),
                  32'(j == v.exp_beats - 1));
        end
        check($sformatf("v%0d_pkt_ok", idx), 32'(ok_seen), 32'(v.exp_ok));
        check($sformatf("v%0d_pkt_drop", idx), 32'(drop_seen), 32'(v.exp_drop));
        check($sformatf("v%0d_drop_count", idx), 32'(drop_count), 32'(v.exp_dcount));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          tl     da       mode nafter tog beats ok drop dcount
        vecs[0] = '{16'd24, LocalIp, 0, 4,  1'b0, 4, 1, 0, 0};  // normal delivery
        vecs[1] = '{16'd24, OtherIp, 0, 4,  1'b0, 0, 0, 1, 1};  // address mismatch
        vecs[2] = '{16'd24, LocalIp, 1, 4,  1'b0, 0, 0, 1, 2};  // err wins over done
        vecs[3] = '{16'd24, LocalIp, 2, 4,  1'b0, 0, 0, 1, 3};  // decoder timeout
        vecs[4] = '{16'd22, LocalIp, 0, 26, 1'b0, 2, 1, 0, 3};  // 46-byte padded frame
        vecs[5] = '{16'd24, BcastIp, 0, 4,  1'b1, 4, 1, 0, 3};  // broadcast, m_ready 1010
        vecs[6] = '{16'd20, LocalIp, 0, 6,  1'b0, 0, 1, 0, 3};  // empty payload + padding
        vecs[7] = '{16'd18, LocalIp, 0, 4,  1'b0, 0, 0, 1, 4};  // total_len below header

        // Reset state.
        @(negedge clk);
        s_valid = 1'b1;
        #1;
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_s_ready", 32'(s_ready), 32'd1);
        check("idle_dec_valid", 32'(dec_valid), 32'd0);
        check("idle_dec_din", 32'(dec_din), 32'd0);
        check("idle_pkt_ok", 32'(pkt_ok), 32'd0);
        check("idle_pkt_drop", 32'(pkt_drop), 32'd0);
        check("idle_drop_count", 32'(drop_count), 32'd0);

        for (int i = 0; i < 8; i++) run_pkt(vecs[i], i);

        // s_last on header byte 10: immediate drop, decoder valid released.
        for (int i = 0; i < 10; i++) push(hdr_byte(i, 16'd40), 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("hdr_dec_valid_high", 32'(dec_valid), 32'd1);
        check("hdr_dec_din", 32'(dec_din), 32'h09);
        push(8'h0A, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        check("hdr_trunc_dec_valid_low", 32'(dec_valid), 32'd0);
        check("hdr_trunc_pkt_drop", 32'(pkt_drop), 32'd1);
        check("hdr_trunc_drop_count", 32'(drop_count), 32'd5);
        check("hdr_trunc_idle", 32'(s_ready), 32'd1);

        // Reset in the middle of a payload.
        send_hdr(16'd30, 1'b0);
        respond(LocalIp, 0);
        for (int k = 0; k < 3; k++) push(pay_byte(k), 1'b0, 1'b0);
        ok_seen   = 0;
        drop_seen = 0;
        @(negedge clk);
        rst     = 1'b1;
        s_valid = 1'b1;
        #1;
        check("midrst_s_ready", 32'(s_ready), 32'd0);
        check("midrst_m_valid", 32'(m_valid), 32'd0);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        @(negedge clk);
        rst     = 1'b0;
        s_valid = 1'b1;
        #1;
        check("postrst_not_payload", 32'(m_valid), 32'd0);
        s_valid = 1'b0;
        check("postrst_drop_count", 32'(drop_count), 32'd0);
        check("postrst_dec_valid", 32'(dec_valid), 32'd0);
        check("postrst_pkt_ok", 32'(pkt_ok), 32'd0);
        check("postrst_pkt_drop", 32'(pkt_drop), 32'd0);
        check("postrst_no_pulses", 32'(ok_seen + drop_seen), 32'd0);
        run_pkt(vecs[0], 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
